// File: rtl/segment_select_delay_pipe.sv
// segment_select_delay_pipe: multi-channel select-and-delay stage.
// Each channel selects array_ref_wire when input_bit == zero and
// array_ref_m_wire otherwise. The selected word and its branch bit then pass
// through a DEPTH-stage pipeline. An occupancy tag travels with the data, and
// stall freezes every stage.
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous active-low reset
//   start            transaction request; operands are sampled with it
//   stall            freezes the pipeline; start is ignored while it is high
//   input_bit, zero  per-channel compare operands, channel c = [c*WIDTH +: WIDTH]
//   array_ref_wire   per-channel value taken on equality
//   array_ref_m_wire per-channel value taken on inequality
//   segment          registered delayed result
//   sel_mask         registered per-channel branch bit (1 = inequality branch)
//   valid            one-cycle pulse per retired transaction
//   busy             high while any stage is occupied
//   done_count       retired-transaction counter, wraps silently
module segment_select_delay_pipe #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stall,
  input  logic [CHANNELS*WIDTH-1:0]    input_bit,
  input  logic [CHANNELS*WIDTH-1:0]    zero,
  input  logic [CHANNELS*WIDTH-1:0]    array_ref_wire,
  input  logic [CHANNELS*WIDTH-1:0]    array_ref_m_wire,
  output logic [CHANNELS*WIDTH-1:0]    segment,
  output logic                         valid,
  output logic                         busy,
  output logic [CHANNELS-1:0]          sel_mask,
  output logic [CNT_W-1:0]             done_count
);

  localparam int unsigned DW = CHANNELS * WIDTH;

  logic [DW-1:0]       stage_data [DEPTH];
  logic [CHANNELS-1:0] stage_sel  [DEPTH];
  logic [DEPTH-1:0]    stage_tag;

  logic [DW-1:0]       sel_data_c;
  logic [CHANNELS-1:0] sel_c;
  logic                accept_c;
  logic                busy_next_c;

  // Per-channel full-width compare and branch select.
  always_comb begin
    sel_c      = '0;
    sel_data_c = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      sel_c[c] = (input_bit[c*WIDTH +: WIDTH] != zero[c*WIDTH +: WIDTH]);
      sel_data_c[c*WIDTH +: WIDTH] = sel_c[c] ? array_ref_m_wire[c*WIDTH +: WIDTH]
                                              : array_ref_wire[c*WIDTH +: WIDTH];
    end
  end

  assign accept_c = start & ~stall;

  // Occupancy after an unstalled shift: the new stage-0 tag plus every tag
  // that moves forward. The last-stage tag retires and is therefore excluded.
  always_comb begin
    busy_next_c = accept_c;
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      busy_next_c = busy_next_c | stage_tag[i];
    end
  end

  // Pipeline shift, output retirement and counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_data[i] <= '0;
        stage_sel[i]  <= '0;
      end
      stage_tag  <= '0;
      segment    <= '0;
      sel_mask   <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      done_count <= '0;
    end else if (stall) begin
      valid <= 1'b0;
    end else begin
      stage_data[0] <= sel_data_c;
      stage_sel[0]  <= sel_c;
      stage_tag[0]  <= accept_c;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_data[i] <= stage_data[i-1];
        stage_sel[i]  <= stage_sel[i-1];
        stage_tag[i]  <= stage_tag[i-1];
      end
      busy <= busy_next_c;
      if (stage_tag[DEPTH-1]) begin
        segment    <= stage_data[DEPTH-1];
        sel_mask   <= stage_sel[DEPTH-1];
        valid      <= 1'b1;
        done_count <= done_count + CNT_W'(1);
      end else begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_segment_select_delay_pipe.sv
// Randomized bench for segment_select_delay_pipe.
// The reference model keeps a queue of in-flight transactions. Each queue
// entry records how many unstalled edges it has seen. An entry retires on
// the edge where that count reaches DEPTH.
module tb_segment_select_delay_pipe;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned CHANNELS = 4;
  localparam int unsigned DEPTH    = 2;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned DW       = WIDTH * CHANNELS;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic                stall;
  logic [DW-1:0]       input_bit;
  logic [DW-1:0]       zero;
  logic [DW-1:0]       array_ref_wire;
  logic [DW-1:0]       array_ref_m_wire;
  logic [DW-1:0]       segment;
  logic                valid;
  logic                busy;
  logic [CHANNELS-1:0] sel_mask;
  logic [CNT_W-1:0]    done_count;

  always #5 clk = ~clk;

  segment_select_delay_pipe #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .input_bit(input_bit), .zero(zero),
    .array_ref_wire(array_ref_wire), .array_ref_m_wire(array_ref_m_wire),
    .segment(segment), .valid(valid), .busy(busy),
    .sel_mask(sel_mask), .done_count(done_count)
  );

  typedef struct {
    logic [DW-1:0]       seg;
    logic [CHANNELS-1:0] sel;
    int                  age;
  } txn_t;

  txn_t                q[$];
  logic [DW-1:0]       exp_seg;
  logic [CHANNELS-1:0] exp_sel;
  logic                exp_valid;
  logic                exp_busy;
  int                  exp_cnt;
  int                  vectors = 0;
  int                  errors  = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model for one rising edge, using the inputs present at that edge.
  task automatic model_edge();
    txn_t t;
    if (!reset) begin
      q.delete();
      exp_seg = '0; exp_sel = '0; exp_valid = 1'b0; exp_busy = 1'b0; exp_cnt = 0;
    end else if (stall) begin
      exp_valid = 1'b0;
    end else begin
      foreach (q[i]) q[i].age++;
      exp_valid = 1'b0;
      if (q.size() > 0 && q[0].age == int'(DEPTH)) begin
        exp_seg   = q[0].seg;
        exp_sel   = q[0].sel;
        exp_valid = 1'b1;
        exp_cnt   = (exp_cnt + 1) % (1 << CNT_W);
        void'(q.pop_front());
      end
      if (start) begin
        t.age = 0;
        t.seg = '0;
        t.sel = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
          t.sel[c] = input_bit[c*WIDTH +: WIDTH] != zero[c*WIDTH +: WIDTH];
          t.seg[c*WIDTH +: WIDTH] = t.sel[c] ? array_ref_m_wire[c*WIDTH +: WIDTH]
                                             : array_ref_wire[c*WIDTH +: WIDTH];
        end
        q.push_back(t);
      end
      exp_busy = q.size() > 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("segment",    segment,        exp_seg);
    check("sel_mask",   DW'(sel_mask),  DW'(exp_sel));
    check("valid",      DW'(valid),     DW'(exp_valid));
    check("busy",       DW'(busy),      DW'(exp_busy));
    check("done_count", DW'(done_count), DW'(exp_cnt));
  endtask

  // Random operands. A channel's compare is forced equal with probability 1/2.
  task automatic rand_data();
    for (int c = 0; c < int'(CHANNELS); c++) begin
      zero[c*WIDTH +: WIDTH]             = $urandom;
      input_bit[c*WIDTH +: WIDTH]        = ($urandom % 2 == 0) ? zero[c*WIDTH +: WIDTH] : $urandom;
      array_ref_wire[c*WIDTH +: WIDTH]   = $urandom;
      array_ref_m_wire[c*WIDTH +: WIDTH] = $urandom;
    end
  endtask

  initial begin
    logic [DW-1:0] branch_exp;
    reset = 1'b0; start = 1'b1; stall = 1'b0;
    rand_data();

    // Reset held with start asserted.
    repeat (3) cycle();
    check("reset_segment", segment, '0);

    // Branch select.
    reset = 1'b1;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      zero[c*WIDTH +: WIDTH]             = 32'd5;
      input_bit[c*WIDTH +: WIDTH]        = (c == 1) ? 32'd6 : 32'd5;
      array_ref_wire[c*WIDTH +: WIDTH]   = 32'hA0 + 32'(c);
      array_ref_m_wire[c*WIDTH +: WIDTH] = 32'hB0 + 32'(c);
    end
    cycle();
    start = 1'b0;
    rand_data();
    repeat (DEPTH) cycle();
    branch_exp = {32'hA3, 32'hA2, 32'hB1, 32'hA0};
    check("branch_segment", segment, branch_exp);
    check("branch_sel",     DW'(sel_mask), DW'(4'b0010));
    check("branch_valid",   DW'(valid), DW'(1'b1));
    repeat (3) cycle();

    // Streaming with a 3-cycle stall in the middle while start is held.
    for (int k = 1; k <= 8; k++) begin
      rand_data();
      input_bit[WIDTH-1:0]      = zero[WIDTH-1:0];
      array_ref_wire[WIDTH-1:0] = 32'(k);
      start = 1'b1;
      if (k == 5) begin
        stall = 1'b1;
        repeat (3) cycle();
        stall = 1'b0;
      end
      cycle();
    end
    start = 1'b0;
    repeat (DEPTH + 2) cycle();

    // Reset one cycle after two accepts.
    start = 1'b1;
    rand_data(); cycle();
    rand_data(); cycle();
    start = 1'b0;
    cycle();
    reset = 1'b0;
    cycle();
    check("midreset_busy", DW'(busy), DW'(1'b0));
    reset = 1'b1;
    repeat (DEPTH + 2) cycle();

    // Randomized traffic, long enough to wrap the 4-bit counter several times.
    for (int n = 0; n < 400; n++) begin
      rand_data();
      start = 1'($urandom % 3 != 0);
      stall = 1'($urandom % 5 == 0);
      reset = 1'($urandom % 60 != 0);
      cycle();
    end
    reset = 1'b1; stall = 1'b0; start = 1'b0;
    repeat (DEPTH + 2) cycle();

    // Counter wrap from a clean reset: 17 back-to-back transactions.
    reset = 1'b0; cycle();
    reset = 1'b1; start = 1'b1;
    for (int n = 0; n < 17; n++) begin
      rand_data();
      cycle();
    end
    start = 1'b0;
    repeat (DEPTH + 1) cycle();
    check("wrap_count", DW'(done_count), DW'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
